// File: rtl/lsu_stall_ctrl_if.sv
// Memory-side bus of the LSU: per-thread read and write valid/ready channels.
// master = LSU (drives requests), slave = memory (drives readies and read data).
interface lsu_stall_ctrl_if #(
  parameter int THREADS   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [THREADS-1:0]           mem_read_valid;
  logic [THREADS*ADDR_BITS-1:0] mem_read_address;
  logic [THREADS-1:0]           mem_read_ready;
  logic [THREADS*DATA_BITS-1:0] mem_read_data;
  logic [THREADS-1:0]           mem_write_valid;
  logic [THREADS*ADDR_BITS-1:0] mem_write_address;
  logic [THREADS*DATA_BITS-1:0] mem_write_data;
  logic [THREADS-1:0]           mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_stall_ctrl.sv
// MEM-stage load/store controller. Launches one memory transaction per active
// thread and stalls the pipeline (any_lsu_waiting) until all have completed.
// Optional watchdog: define LSU_TIMEOUT_EN to add the counter and lsu_timeout.
module lsu_stall_ctrl #(
  parameter int THREADS        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         mem_read_en,
  input  logic                         mem_write_en,
  input  logic [THREADS-1:0]           thread_enable,
  input  logic [THREADS*ADDR_BITS-1:0] rs_addr,
  input  logic [THREADS*DATA_BITS-1:0] rt_data,
  lsu_stall_ctrl_if.master             mem,
  output logic [THREADS*DATA_BITS-1:0] lsu_out,
`ifdef LSU_TIMEOUT_EN
  output logic                         lsu_timeout,
`endif
  output logic                         any_lsu_waiting
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [THREADS-1:0][1:0]           state_q, state_d;
  logic [THREADS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
  logic [THREADS-1:0][DATA_BITS-1:0] data_q, data_d;
  logic [THREADS-1:0][DATA_BITS-1:0] lsu_out_q, lsu_out_d;
  logic [THREADS-1:0]                rvalid_q, rvalid_d;
  logic [THREADS-1:0]                wvalid_q, wvalid_d;
  logic                              op_read_q, op_read_d;
  logic                              all_idle, any_req, start;

  // Summarise the per-thread FSMs
  always_comb begin
    all_idle = 1'b1;
    any_req  = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (state_q[i] != S_IDLE) all_idle = 1'b0;
      if (state_q[i] == S_REQ)  any_req  = 1'b1;
    end
  end

  // A new op may only launch once every thread is back to IDLE, so the same
  // instruction cannot re-issue during the all-DONE release cycle.
  assign start = issue_valid & (mem_read_en | mem_write_en) & all_idle &
                 (|thread_enable);
  assign any_lsu_waiting = start | any_req;

  // Per-thread next state, request launch, completion and load capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    lsu_out_d = lsu_out_q;
    rvalid_d  = rvalid_q;
    wvalid_d  = wvalid_q;
    op_read_d = start ? mem_read_en : op_read_q;  // read wins if both set
    for (int i = 0; i < THREADS; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (start && thread_enable[i]) begin
            state_d[i]  = S_REQ;
            addr_d[i]   = rs_addr[i*ADDR_BITS +: ADDR_BITS];
            data_d[i]   = rt_data[i*DATA_BITS +: DATA_BITS];
            rvalid_d[i] = mem_read_en;
            wvalid_d[i] = ~mem_read_en;
          end
        end
        S_REQ: begin
          if (op_read_q ? mem.mem_read_ready[i] : mem.mem_write_ready[i]) begin
            state_d[i]  = S_DONE;
            rvalid_d[i] = 1'b0;
            wvalid_d[i] = 1'b0;
            if (op_read_q) lsu_out_d[i] = mem.mem_read_data[i*DATA_BITS +: DATA_BITS];
          end
        end
        S_DONE: begin
          if (!any_req) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any outstanding transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      lsu_out_q <= '0;
      rvalid_q  <= '0;
      wvalid_q  <= '0;
      op_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      lsu_out_q <= lsu_out_d;
      rvalid_q  <= rvalid_d;
      wvalid_q  <= wvalid_d;
      op_read_q <= op_read_d;
    end
  end

  assign mem.mem_read_valid    = rvalid_q;
  assign mem.mem_write_valid   = wvalid_q;
  assign mem.mem_read_address  = addr_q;
  assign mem.mem_write_address = addr_q;
  assign mem.mem_write_data    = data_q;
  assign lsu_out               = lsu_out_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          lsu_timeout_q, lsu_timeout_d;

  // Count cycles spent with a request outstanding; saturate and latch the flag
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (start)                              to_cnt_d = '0;
    else if (any_req && to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
    lsu_timeout_d = lsu_timeout_q | (to_cnt_d == TO_MAX);
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q      <= '0;
      lsu_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      lsu_timeout_q <= lsu_timeout_d;
    end
  end

  assign lsu_timeout = lsu_timeout_q;
`endif

endmodule

// File: tb/tb_lsu_stall_ctrl.sv
// Directed bench for lsu_stall_ctrl. Inputs change 2 time units after the
// rising edge; outputs are checked 1 unit later, well clear of the next edge.
module tb_lsu_stall_ctrl;
`ifdef LSU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, mem_read_en, mem_write_en;
  logic [3:0]  thread_enable;
  logic [31:0] rs_addr, rt_data, lsu_out;
  logic        any_lsu_waiting;
`ifdef LSU_TIMEOUT_EN
  logic        lsu_timeout;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  lsu_stall_ctrl_if #(.THREADS(4), .ADDR_BITS(8), .DATA_BITS(8)) mif ();

  lsu_stall_ctrl #(.THREADS(4), .ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .thread_enable   (thread_enable),
    .rs_addr         (rs_addr),
    .rt_data         (rt_data),
    .mem             (mif),
    .lsu_out         (lsu_out),
`ifdef LSU_TIMEOUT_EN
    .lsu_timeout     (lsu_timeout),
`endif
    .any_lsu_waiting (any_lsu_waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // staggered-ready table: per cycle after start, read_ready and read_data
  logic [3:0]  stg_rdy [0:6];
  logic [31:0] stg_dat [0:6];
  logic        stg_stl [0:6];

  initial begin
    reset = 1'b1; issue_valid = 0; mem_read_en = 0; mem_write_en = 0;
    thread_enable = 0; rs_addr = 0; rt_data = 0;
    mif.mem_read_ready = 0; mif.mem_write_ready = 0; mif.mem_read_data = 0;

    // ---- reset state
    nxt(); nxt();
    reset = 1'b0;
    #1;
    chk("rst_rvalid", 64'(mif.mem_read_valid), 0);
    chk("rst_wvalid", 64'(mif.mem_write_valid), 0);
    chk("rst_raddr",  64'(mif.mem_read_address), 0);
    chk("rst_wdata",  64'(mif.mem_write_data), 0);
    chk("rst_lsuout", 64'(lsu_out), 0);
    chk("rst_stall",  64'(any_lsu_waiting), 0);
`ifdef LSU_TIMEOUT_EN
    chk("rst_timeout", 64'(lsu_timeout), 0);
`endif

    // ---- load, 4 threads, ready in first request cycle
    nxt();
    issue_valid = 1; mem_read_en = 1; thread_enable = 4'hF; rs_addr = 32'h13121110;
    #1;
    chk("ld_stall_N",  64'(any_lsu_waiting), 1);
    chk("ld_rvalid_N", 64'(mif.mem_read_valid), 0);
    nxt();
    mif.mem_read_ready = 4'hF; mif.mem_read_data = 32'hA3A2A1A0;
    #1;
    chk("ld_stall_N1",  64'(any_lsu_waiting), 1);
    chk("ld_rvalid_N1", 64'(mif.mem_read_valid), 4'hF);
    chk("ld_raddr_N1",  64'(mif.mem_read_address), 32'h13121110);
    chk("ld_wvalid_N1", 64'(mif.mem_write_valid), 0);
    nxt();
    mif.mem_read_ready = 0; mif.mem_read_data = 32'hEEEEEEEE;
    #1;
    chk("ld_stall_N2",  64'(any_lsu_waiting), 0);
    chk("ld_rvalid_N2", 64'(mif.mem_read_valid), 0);
    chk("ld_lsuout",    64'(lsu_out), 32'hA3A2A1A0);

    // ---- store on threads 0/2; starting here also shows the FSMs are IDLE
    nxt();
    mem_read_en = 0; mem_write_en = 1; thread_enable = 4'b0101;
    rs_addr = 32'h23222120; rt_data = 32'h00660055;
    #1;
    chk("st_stall_S", 64'(any_lsu_waiting), 1);
    nxt();
    mif.mem_write_ready = 4'b0101;
    #1;
    chk("st_wvalid",  64'(mif.mem_write_valid), 4'b0101);
    chk("st_rvalid",  64'(mif.mem_read_valid), 0);
    chk("st_waddr",   64'(mif.mem_write_address & 32'h00FF00FF), 32'h00220020);
    chk("st_wdata",   64'(mif.mem_write_data & 32'h00FF00FF), 32'h00660055);
    chk("st_stall_1", 64'(any_lsu_waiting), 1);
    nxt();
    mif.mem_write_ready = 0;
    #1;
    chk("st_stall_2", 64'(any_lsu_waiting), 0);
    chk("st_wvalid2", 64'(mif.mem_write_valid), 0);
    chk("st_lsuout",  64'(lsu_out), 32'hA3A2A1A0);
    nxt();
    issue_valid = 0; mem_write_en = 0;

    // ---- staggered readies: thread 3 at +1, threads 1/2 at +3, thread 0 at +5
    stg_rdy[0] = 4'b0000; stg_dat[0] = 32'hEEEEEEEE; stg_stl[0] = 1;
    stg_rdy[1] = 4'b1000; stg_dat[1] = 32'hB3EEEEEE; stg_stl[1] = 1;
    stg_rdy[2] = 4'b0000; stg_dat[2] = 32'hEEEEEEEE; stg_stl[2] = 1;
    stg_rdy[3] = 4'b0110; stg_dat[3] = 32'hEEB2B1EE; stg_stl[3] = 1;
    stg_rdy[4] = 4'b0000; stg_dat[4] = 32'hEEEEEEEE; stg_stl[4] = 1;
    stg_rdy[5] = 4'b0001; stg_dat[5] = 32'hEEEEEEB0; stg_stl[5] = 1;
    stg_rdy[6] = 4'b0000; stg_dat[6] = 32'hEEEEEEEE; stg_stl[6] = 0;
    nxt();
    issue_valid = 1; mem_read_en = 1; thread_enable = 4'hF; rs_addr = 32'h33323130;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) nxt();
      mif.mem_read_ready = stg_rdy[c]; mif.mem_read_data = stg_dat[c];
      #1;
      chk($sformatf("stg_stall_%0d", c), 64'(any_lsu_waiting), 64'(stg_stl[c]));
    end
    chk("stg_lsuout", 64'(lsu_out), 32'hB3B2B1B0);
    nxt();
    mif.mem_read_ready = 0;
    thread_enable = 4'h0;  // next instruction: memory op with no threads
    #1;
    chk("te0_stall_0", 64'(any_lsu_waiting), 0);
    nxt(); #1;
    chk("te0_stall_1",  64'(any_lsu_waiting), 0);
    chk("te0_rvalid_1", 64'(mif.mem_read_valid), 0);

    // ---- both enables set: read wins
    nxt();
    mem_write_en = 1; thread_enable = 4'hF; rs_addr = 32'h53525150;
    nxt();
    mif.mem_read_ready = 4'hF; mif.mem_read_data = 32'hC3C2C1C0;
    #1;
    chk("rw_rvalid", 64'(mif.mem_read_valid), 4'hF);
    chk("rw_wvalid", 64'(mif.mem_write_valid), 0);
    nxt();
    mif.mem_read_ready = 0; mem_write_en = 0;
    #1;
    chk("rw_lsuout", 64'(lsu_out), 32'hC3C2C1C0);
    nxt();
    issue_valid = 0;

    // ---- reset mid-transaction with threads 0/1 requesting
    nxt();
    issue_valid = 1; thread_enable = 4'b0011; rs_addr = 32'h00004140;
    nxt();
    issue_valid = 0;
    #1;
    chk("rs_rvalid_pre", 64'(mif.mem_read_valid), 4'b0011);
    nxt();
    reset = 1;
    nxt();
    reset = 0; mif.mem_read_ready = 4'b0011; mif.mem_read_data = 32'h77777777;
    #1;
    chk("rs_rvalid",  64'(mif.mem_read_valid), 0);
    chk("rs_stall",   64'(any_lsu_waiting), 0);
    chk("rs_lsuout",  64'(lsu_out), 0);
    nxt();
    mif.mem_read_ready = 0;
    #1;
    chk("rs_lsuout_late", 64'(lsu_out), 0);
    chk("rs_stall_late",  64'(any_lsu_waiting), 0);

`ifdef LSU_TIMEOUT_EN
    // ---- watchdog: ready withheld for more than TIMEOUT_CYCLES
    nxt();
    issue_valid = 1; thread_enable = 4'b0001; rs_addr = 32'h00000060;
    #1;
    chk("to_flag_N", 64'(lsu_timeout), 0);
    for (int k = 1; k <= 9; k++) begin
      nxt(); #1;
      chk($sformatf("to_flag_N%0d", k), 64'(lsu_timeout), (k >= 9) ? 64'd1 : 64'd0);
    end
    mif.mem_read_ready = 4'b0001; mif.mem_read_data = 32'h0000005A;
    nxt();
    mif.mem_read_ready = 0; issue_valid = 0;
    #1;
    chk("to_done_stall", 64'(any_lsu_waiting), 0);
    chk("to_done_data",  64'(lsu_out), 32'h0000005A);
    nxt(); nxt(); #1;
    chk("to_sticky", 64'(lsu_timeout), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
